exu_muldiv_ctrl: RTL

//  Sequencer for the multi-cycle M-extension resource in the execute stage.
//  - Accepts one MUL/DIV/REM op from the EX operand muxes (post-forwarding operand_a/operand_b).
//  - Runs an iterative shift-add multiply or a restoring divide, one bit per cycle.
//  - Holds the pipeline via stall_o until the result is ready.
//  - Its result is muxed onto the EX ALU result path; stall_o is ORed into the ALU stall.
//

---
 rtl/exu_muldiv_ctrl_pkg.sv | 36 +++
 rtl/md_iter_dp.sv | 93 +++++++++
 rtl/exu_muldiv_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : exu_muldiv_ctrl_pkg
//  Description : Shared types for the execute-stage multiply/divide sequencer.
//                muldiv_op_e follows the RISC-V M-extension funct3 ordering,
//                so op_i can be driven straight from the decoded funct3 field.
//  Revision    : 1.0 - initial release
// ============================================================================
package exu_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_CALC = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    // DIV/DIVU/REM/REMU all share the restoring-divide datapath.
    function automatic logic is_div_op(input muldiv_op_e op);
        return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
    endfunction

endpackage : exu_muldiv_ctrl_pkg
`default_nettype wire

// File: rtl/md_iter_dp.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_dp
//  Description : One-bit-per-cycle iterative datapath shared by multiply and
//                divide. A single 2*XLEN accumulator holds either the
//                {high, low} product or the {remainder, quotient} pair.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i       in   1     core clock
//    rst_ni      in   1     asynchronous active-low reset
//    div_mode_i  in   1     1 = restoring divide step, 0 = shift-add multiply
//    load_i      in   1     load unsigned operands, clear the upper half
//    step_i      in   1     perform one iteration
//    a_i         in   XLEN  multiplier / dividend magnitude
//    b_i         in   XLEN  multiplicand / divisor magnitude
//    acc_hi_o    out  XLEN  product high half / remainder
//    acc_lo_o    out  XLEN  product low half / quotient
// ============================================================================
module md_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            div_mode_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] acc_hi_o,
    output logic [XLEN-1:0] acc_lo_o
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;

    assign w_hi = r_acc[2*XLEN-1:XLEN];
    assign w_lo = r_acc[XLEN-1:0];

    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit (LSB of the low half) is set; the carry becomes the new
    // MSB when the whole register shifts right.
    assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : '0);

    // Divide: shift the next dividend bit into the partial remainder. The
    // XLEN+1-bit subtract wraps into bit XLEN exactly when the shifted
    // remainder is smaller than the divisor, unless the shifted value itself
    // already carries a bit in position XLEN.
    assign w_shift = {w_hi, w_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};
    assign w_ge    = w_shift[XLEN] | ~w_diff[XLEN];

    always_comb begin
        w_acc_next = r_acc;
        if (load_i) begin
            w_acc_next = {{XLEN{1'b0}}, a_i};
        end else if (step_i) begin
            if (div_mode_i) begin
                if (w_ge) begin
                    w_acc_next = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
                end else begin
                    w_acc_next = {w_shift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                w_acc_next = {w_sum, w_lo[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
            r_opb <= '0;
        end else begin
            r_acc <= w_acc_next;
            if (load_i) begin
                r_opb <= b_i;
            end
        end
    end

    assign acc_hi_o = w_hi;
    assign acc_lo_o = w_lo;

endmodule : md_iter_dp
`default_nettype wire

// File: rtl/exu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exu_muldiv_ctrl
//  Description : Execute-stage sequencer for the M-extension. Accepts one
//                MUL/DIV/REM op, runs it through md_iter_dp one bit per cycle,
//                holds the pipeline with stall_o and presents a registered
//                result with valid_o for one cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i     in   1     core clock
//    rst_ni    in   1     asynchronous active-low reset
//    start_i   in   1     EX holds a valid M op (level, held while stalled)
//    op_i      in   3     muldiv_op_e (funct3 order)
//    a_i       in   XLEN  operand A (rs1 after forwarding)
//    b_i       in   XLEN  operand B (rs2 after forwarding)
//    flush_i   in   1     EX instruction killed
//    stall_o   out  1     hold IF/ID/EX
//    valid_o   out  1     result_o valid this cycle
//    result_o  out  XLEN  final result (registered)
// ============================================================================
module exu_muldiv_ctrl
    import exu_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int                c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   c_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e           r_state;
    md_state_e           w_state_next;
    muldiv_op_e          r_op;
    muldiv_op_e          w_op_in;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_neg;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;
    logic                w_a_zero;
    logic                w_b_zero;
    logic                w_ovf;

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_neg_prep;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;

    logic                w_dp_load;
    logic                w_dp_step;
    logic [XLEN-1:0]     w_acc_hi;
    logic [XLEN-1:0]     w_acc_lo;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_fix_res;

    assign w_op_in  = muldiv_op_e'(op_i);
    assign w_accept = (r_state == MD_IDLE) && start_i && !flush_i;

    // ------------------------------------------------------------------------
    // Fast path: results that need no iteration are decided from the live
    // operands in the accept cycle and land in result_o one cycle later.
    // ------------------------------------------------------------------------
    assign w_a_zero = (a_i == '0);
    assign w_b_zero = (b_i == '0);
    assign w_ovf    = (a_i == c_MIN_INT) && (b_i == '1);

    always_comb begin
        w_fast     = 1'b0;
        w_fast_res = '0;
        case (w_op_in)
            MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU: begin
                if (w_a_zero || w_b_zero) begin
                    w_fast     = 1'b1;
                    w_fast_res = '0;
                end
            end
            MD_DIV: begin
                if (w_b_zero) begin
                    w_fast     = 1'b1;
                    w_fast_res = '1;
                end else if (w_ovf) begin
                    w_fast     = 1'b1;
                    w_fast_res = a_i;
                end
            end
            MD_DIVU: begin
                if (w_b_zero) begin
                    w_fast     = 1'b1;
                    w_fast_res = '1;
                end
            end
            MD_REM: begin
                if (w_b_zero) begin
                    w_fast     = 1'b1;
                    w_fast_res = a_i;
                end else if (w_ovf) begin
                    w_fast     = 1'b1;
                    w_fast_res = '0;
                end
            end
            MD_REMU: begin
                if (w_b_zero) begin
                    w_fast     = 1'b1;
                    w_fast_res = a_i;
                end
            end
            default: begin
                w_fast     = 1'b0;
                w_fast_res = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand conditioning. MUL only needs the low half, which is identical
    // for signed and unsigned inputs, so it is treated as unsigned.
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (r_op)
            MD_MULH, MD_DIV, MD_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            MD_MULHSU: begin
                w_a_signed = 1'b1;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
    end

    assign w_a_neg = w_a_signed & r_a[XLEN-1];
    assign w_b_neg = w_b_signed & r_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~r_a + 1'b1) : r_a;
    assign w_b_mag = w_b_neg ? (~r_b + 1'b1) : r_b;

    // Remainder takes the dividend's sign; products and quotients take the
    // XOR of both operand signs.
    always_comb begin
        w_neg_prep = 1'b0;
        case (r_op)
            MD_MULH, MD_MULHSU, MD_DIV: w_neg_prep = w_a_neg ^ w_b_neg;
            MD_REM:                     w_neg_prep = w_a_neg;
            default:                    w_neg_prep = 1'b0;
        endcase
    end

    md_iter_dp #(
        .XLEN(XLEN)
    ) u_dp (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .div_mode_i (is_div_op(r_op)),
        .load_i     (w_dp_load),
        .step_i     (w_dp_step),
        .a_i        (w_a_mag),
        .b_i        (w_b_mag),
        .acc_hi_o   (w_acc_hi),
        .acc_lo_o   (w_acc_lo)
    );

    // ------------------------------------------------------------------------
    // Sign fix-up and result selection. The full product is negated so the
    // borrow from the low half propagates correctly into MULH/MULHSU.
    // ------------------------------------------------------------------------
    assign w_prod_fix = r_neg ? (~{w_acc_hi, w_acc_lo} + 1'b1) : {w_acc_hi, w_acc_lo};
    assign w_quo_fix  = r_neg ? (~w_acc_lo + 1'b1) : w_acc_lo;
    assign w_rem_fix  = r_neg ? (~w_acc_hi + 1'b1) : w_acc_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            MD_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_fix_res = w_quo_fix;
            MD_REM, MD_REMU:              w_fix_res = w_rem_fix;
            default:                      w_fix_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: next state and per-state outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_dp_load    = 1'b0;
        w_dp_step    = 1'b0;
        stall_o      = 1'b0;
        valid_o      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_accept) begin
                    stall_o      = 1'b1;
                    w_state_next = w_fast ? MD_DONE : MD_PREP;
                end
            end
            MD_PREP: begin
                stall_o      = 1'b1;
                w_dp_load    = 1'b1;
                w_state_next = MD_CALC;
            end
            MD_CALC: begin
                stall_o   = 1'b1;
                w_dp_step = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = MD_FIX;
                end
            end
            MD_FIX: begin
                stall_o      = 1'b1;
                w_state_next = MD_DONE;
            end
            MD_DONE: begin
                // A killed instruction must not retire a result.
                valid_o      = !flush_i;
                w_state_next = MD_IDLE;
            end
            default: begin
                w_state_next = MD_IDLE;
            end
        endcase
        if (flush_i) begin
            w_state_next = MD_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= MD_IDLE;
            r_op     <= MD_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op <= w_op_in;
                r_a  <= a_i;
                r_b  <= b_i;
                if (w_fast) begin
                    r_result <= w_fast_res;
                end
            end
            if (r_state == MD_PREP) begin
                r_neg <= w_neg_prep;
                r_cnt <= c_CNT_INIT;
            end
            if ((r_state == MD_CALC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if ((r_state == MD_FIX) && !flush_i) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign result_o = r_result;

endmodule : exu_muldiv_ctrl
`default_nettype wire
